// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared definitions for the CIC interpolator and decimator.
//   - CIC_REGISTER_WIDTH : default internal comb/integrator width
//   - s_register_t       : signed register type at the default width
//   - CIC_DEFAULT_*      : default ratio, stage count, gain and data widths
//   - cic_min_register_width() : smallest internal width that avoids
//     information loss for a given data width, stage count and ratio
// -----------------------------------------------------------------------------
package cic_pkg;

    localparam int CIC_REGISTER_WIDTH     = 64;
    localparam int CIC_DEFAULT_RATIO      = 16;
    localparam int CIC_DEFAULT_STAGES     = 5;
    localparam int CIC_DEFAULT_GAIN_WIDTH = 8;
    localparam int CIC_DEFAULT_DATA_WIDTH = 12;

    typedef logic signed [CIC_REGISTER_WIDTH-1:0] s_register_t;

    // Output growth of an N-stage interpolator is R^(N-1), i.e.
    // (N-1)*log2(R) bits on top of the input width.
    function automatic int cic_min_register_width(input int data_width,
                                                  input int n_stages,
                                                  input int ratio);
        return data_width + (n_stages - 1) * $clog2(ratio);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// -----------------------------------------------------------------------------
// cic_integrator_stage
// One registered accumulator of the CIC integrator chain: out <= out + in.
// The sum wraps modulo 2^WIDTH; the comb section cancels any wrap.
// Ports:
//   clk   : clock (high sample rate)
//   rst_n : asynchronous active-low reset, clears the accumulator
//   in    : value added each clock
//   out   : registered accumulator value
// -----------------------------------------------------------------------------
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int WIDTH = CIC_REGISTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out + in;
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// -----------------------------------------------------------------------------
// cic_interpolator
// Interpolating CIC filter for the transmit/DUC path. Low-rate samples are
// taken through a valid/ready handshake once every INTERPOLATION_RATIO clocks,
// pass N_STAGES comb stages at the low rate, are zero-stuffed, then pass
// N_STAGES integrators at the clk rate. The result is right-shifted by gain.
// Ports:
//   clk            : clock, equal to the output sample rate
//   rst_n          : asynchronous active-low reset
//   gain           : output right-shift amount (unsigned, clamped to width-1)
//   data_in        : signed low-rate sample
//   data_in_valid  : data_in holds a valid sample
//   data_in_ready  : high on the single slot cycle of each frame
//   data_out       : signed high-rate sample
//   data_out_valid : high from the clock after the first slot until reset
//   underrun       : sticky, set when a slot passes without a valid sample
//   sat_flag       : (CIC_INTERPOLATOR_SAT_EN only) output clipped this cycle
// Build option:
//   CIC_INTERPOLATOR_SAT_EN : saturate instead of truncating the output
// -----------------------------------------------------------------------------
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int DATA_WIDTH          = CIC_DEFAULT_DATA_WIDTH,
    parameter int REGISTER_WIDTH      = CIC_REGISTER_WIDTH,
    parameter int INTERPOLATION_RATIO = CIC_DEFAULT_RATIO,
    parameter int GAIN_WIDTH          = CIC_DEFAULT_GAIN_WIDTH,
    parameter int N_STAGES            = CIC_DEFAULT_STAGES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GAIN_WIDTH-1:0] gain,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
`ifdef CIC_INTERPOLATOR_SAT_EN
    output logic                  sat_flag,
`endif
    output logic                  underrun
);

    localparam int PHASE_WIDTH = $clog2(INTERPOLATION_RATIO);
    localparam int SHIFT_WIDTH = $clog2(REGISTER_WIDTH);
    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(INTERPOLATION_RATIO - 1);

    logic [PHASE_WIDTH-1:0]           phase;
    logic                             slot;
    logic                             accept;
    logic                             slot_seen;
    logic signed [REGISTER_WIDTH-1:0] x;
    logic signed [REGISTER_WIDTH-1:0] comb       [N_STAGES];
    // comb_delay[i] holds the previous-slot value of the input of comb stage i
    logic signed [REGISTER_WIDTH-1:0] comb_delay [N_STAGES];
    logic [REGISTER_WIDTH-1:0]        integ      [N_STAGES];
    logic [REGISTER_WIDTH-1:0]        integ_in;
    logic [SHIFT_WIDTH-1:0]           shift;

    // Free-running frame counter; R is a power of two so it wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else begin
            phase <= phase + PHASE_WIDTH'(1);
        end
    end

    assign slot          = (phase == LAST_PHASE);
    assign data_in_ready = slot && rst_n;
    assign accept        = data_in_valid && data_in_ready;

    // A missed slot feeds zero into the combs.
    always_comb begin
        x = '0;
        if (accept) begin
            x = REGISTER_WIDTH'($signed(data_in));
        end
    end

    // Comb chain: every stage registered, advancing once per slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGES; i++) begin
                comb[i]       <= '0;
                comb_delay[i] <= '0;
            end
        end else if (slot) begin
            comb[0]       <= x - comb_delay[0];
            comb_delay[0] <= x;
            for (int i = 1; i < N_STAGES; i++) begin
                comb[i]       <= comb[i-1] - comb_delay[i];
                comb_delay[i] <= comb[i-1];
            end
        end
    end

    // Zero-stuffing: the comb output enters the integrators for one clock
    // per frame, on the cycle right after the slot edge that produced it.
    assign integ_in = (phase == '0) ? comb[N_STAGES-1] : '0;

    for (genvar i = 0; i < N_STAGES; i++) begin : g_integ
        if (i == 0) begin : g_first
            cic_integrator_stage #(.WIDTH(REGISTER_WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .in    (integ_in),
                .out   (integ[i])
            );
        end else begin : g_next
            cic_integrator_stage #(.WIDTH(REGISTER_WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .in    (integ[i-1]),
                .out   (integ[i])
            );
        end
    end

    // Shifts of width or more are meaningless; clamp to the sign bit.
    always_comb begin
        shift = SHIFT_WIDTH'(gain);
        if (int'(gain) > REGISTER_WIDTH - 1) begin
            shift = SHIFT_WIDTH'(REGISTER_WIDTH - 1);
        end
    end

`ifdef CIC_INTERPOLATOR_SAT_EN
    localparam logic signed [REGISTER_WIDTH-1:0] OUT_MAX = REGISTER_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [REGISTER_WIDTH-1:0] OUT_MIN = REGISTER_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    logic signed [REGISTER_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0]            out_next;
    logic                             clip;

    // Clip the scaled value into the signed output range.
    always_comb begin
        shifted  = $signed(integ[N_STAGES-1]) >>> shift;
        clip     = 1'b0;
        out_next = shifted[DATA_WIDTH-1:0];
        if (shifted > OUT_MAX) begin
            out_next = OUT_MAX[DATA_WIDTH-1:0];
            clip     = 1'b1;
        end else if (shifted < OUT_MIN) begin
            out_next = OUT_MIN[DATA_WIDTH-1:0];
            clip     = 1'b1;
        end
    end
`endif

    // Output register plus the valid and underrun status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            slot_seen      <= 1'b0;
            underrun       <= 1'b0;
`ifdef CIC_INTERPOLATOR_SAT_EN
            sat_flag       <= 1'b0;
`endif
        end else begin
`ifdef CIC_INTERPOLATOR_SAT_EN
            data_out       <= out_next;
            sat_flag       <= clip;
`else
            data_out       <= DATA_WIDTH'($signed(integ[N_STAGES-1]) >>> shift);
`endif
            data_out_valid <= slot_seen;
            if (slot) begin
                slot_seen <= 1'b1;
                if (!data_in_valid) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule
